// File: rtl/store_data_aligner_pkg.sv
// ---------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store data aligner:
//   - store size encodings carried on the size port
//   - FSM state type (IDLE / REQ / RESP), also exported for debug
//   - BE_ALL, the full-word byte-enable mask
// ---------------------------------------------------------------------------
package store_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam logic [3:0] BE_ALL = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/store_data_aligner_if.sv
// ---------------------------------------------------------------------------
// store_data_aligner_if
// Bundles the control-unit request side and the data-memory write side of
// the store data aligner.
//   control in : start, size, addr, rt_data
//   memory      : mem_req/mem_ack handshake, mem_addr, mem_wdata, mem_be
//   status out  : busy, done, misalign, timeout
//   debug out   : dbg_state (current FSM state)
// Modports: slave = the aligner, master = the environment driving it.
//
// Handshake: mem_req rises when a legal store enters REQ and stays high,
// with mem_addr/mem_wdata/mem_be held stable, until mem_ack is sampled
// high on a rising edge (an ack in the very first REQ cycle counts). The
// cycle after that edge mem_req is low. mem_ack while mem_req is low has
// no effect.
// ---------------------------------------------------------------------------
interface store_data_aligner_if #(
   parameter int ADDR_W = 32
);
   import store_pkg::*;

   logic              start;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       rt_data;
   logic              mem_ack;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic              busy;
   logic              done;
   logic              misalign;
   logic              timeout;
   state_t            dbg_state;

   modport slave (
      input  start, size, addr, rt_data, mem_ack,
      output mem_req, mem_addr, mem_wdata, mem_be,
      output busy, done, misalign, timeout, dbg_state
   );

   modport master (
      output start, size, addr, rt_data, mem_ack,
      input  mem_req, mem_addr, mem_wdata, mem_be,
      input  busy, done, misalign, timeout, dbg_state
   );

endinterface

// File: rtl/store_data_aligner_lane_packer.sv
// ---------------------------------------------------------------------------
// store_lane_packer
// Purely combinational: replicates the narrowed register value across the
// byte lanes and produces little-endian byte enables for the store.
//   i_size     : store size (store_pkg SZ_* encodings)
//   i_addr_lo  : byte address bits [1:0]
//   i_rt_data  : register value
//   o_wdata    : lane-replicated write data
//   o_be       : byte enables, bit i = lane i (0 when misaligned)
//   o_misalign : size/address combination cannot be stored
// ---------------------------------------------------------------------------
module store_lane_packer
   import store_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_rt_data,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_be,
   output logic        o_misalign
);

   always_comb begin
      o_wdata    = i_rt_data;
      o_be       = 4'b0000;
      o_misalign = 1'b0;
      case (i_size)
         SZ_BYTE: begin
            o_wdata = {4{i_rt_data[7:0]}};
            o_be    = 4'b0001 << i_addr_lo;
         end
         SZ_HALF: begin
            o_wdata    = {2{i_rt_data[15:0]}};
            o_misalign = i_addr_lo[0];
            o_be       = i_addr_lo[0] ? 4'b0000 :
                         (i_addr_lo[1] ? 4'b1100 : 4'b0011);
         end
         SZ_WORD: begin
            o_misalign = (i_addr_lo != 2'b00);
            o_be       = (i_addr_lo != 2'b00) ? 4'b0000 : BE_ALL;
         end
         default: begin
            // reserved size: always rejected
            o_misalign = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/store_data_aligner.sv
// ---------------------------------------------------------------------------
// store_data_aligner
// Store path of the multicycle CPU: narrows rt_data to byte/half/word,
// places it on the memory byte lanes and runs the data-memory write
// handshake during the MEM phase of SB/SH/SW.
//   CLK    : system clock, rising edge
//   Reset  : synchronous, active-high
//   bus    : store_data_aligner_if.slave (request, memory, status, debug)
// Parameters: ADDR_W (address width), TIMEOUT_CYCLES (REQ cycles without
// ack before abort).
// Build option: define SDA_TIMEOUT_EN to enable the REQ timeout; without
// it REQ waits indefinitely and timeout is tied low.
// ---------------------------------------------------------------------------
module store_data_aligner
   import store_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 CLK,
   input  logic                 Reset,
   store_data_aligner_if.slave  bus
);

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_be;
   logic              r_misalign;

   logic [31:0]       w_pk_wdata;
   logic [3:0]        w_pk_be;
   logic              w_pk_misalign;
   logic              w_accept;

   store_lane_packer u_packer (
      .i_size     (bus.size),
      .i_addr_lo  (bus.addr[1:0]),
      .i_rt_data  (bus.rt_data),
      .o_wdata    (w_pk_wdata),
      .o_be       (w_pk_be),
      .o_misalign (w_pk_misalign)
   );

   // start only matters in IDLE; anywhere else it is dropped, not queued
   assign w_accept = (r_state == IDLE) && bus.start;

`ifdef SDA_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;
   logic             w_to_hit;

   // counter sits at 0 outside REQ, so it is already clear on REQ entry
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_cnt <= '0;
      end else if (r_state != REQ) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_timeout <= 1'b0;
      end else if (w_accept) begin
         r_timeout <= 1'b0;
      end else if (w_to_hit) begin
         r_timeout <= 1'b1;
      end
   end
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

   always_comb begin
      w_next_state = r_state;
`ifdef SDA_TIMEOUT_EN
      w_to_hit     = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_next_state = w_pk_misalign ? RESP : REQ;
            end
         end
         REQ: begin
            // an ack in the expiry cycle wins over the timeout
            if (bus.mem_ack) begin
               w_next_state = RESP;
            end
`ifdef SDA_TIMEOUT_EN
            else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_next_state = RESP;
               w_to_hit     = 1'b1;
            end
`endif
         end
         RESP: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= 4'b0000;
         r_misalign <= 1'b0;
      end else begin
         r_state <= w_next_state;
         // payload captured once at acceptance and held until the next one
         if (w_accept) begin
            r_addr     <= {bus.addr[ADDR_W-1:2], 2'b00};
            r_wdata    <= w_pk_wdata;
            r_be       <= w_pk_misalign ? 4'b0000 : w_pk_be;
            r_misalign <= w_pk_misalign;
         end
      end
   end

   assign bus.mem_req   = (r_state == REQ);
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = (r_state == RESP);
   assign bus.misalign  = (r_state == RESP) && r_misalign;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_be    = r_be;
   assign bus.dbg_state = r_state;
`ifdef SDA_TIMEOUT_EN
   assign bus.timeout   = (r_state == RESP) && r_timeout;
`else
   assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_store_data_aligner.sv
// ---------------------------------------------------------------------------
// tb_store_data_aligner
// Self-checking bench for store_data_aligner. Directed scenarios plus a
// randomized run checked against a reference model built from the store
// rules (lane arithmetic, misalignment rules, cycle counts).
// ---------------------------------------------------------------------------
module tb_store_data_aligner;
   import store_pkg::*;

`ifdef SDA_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
   localparam int TO    = 4;
`else
   localparam bit TO_EN = 1'b0;
   localparam int TO    = 16;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   store_data_aligner_if #(.ADDR_W(32)) bus ();

   store_data_aligner #(
      .ADDR_W         (32),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLK   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // scoreboard queues: expected memory payload per random store
   logic [31:0] exp_q[$];
   logic [3:0]  exp_be_q[$];

   typedef struct {
      int          req_cycles;
      int          done_cyc;
      logic        mis;
      logic        to;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      bit          stable;
      logic        post_busy;
      logic        post_done;
      logic [31:0] post_wdata;
      logic [3:0]  post_be;
   } obs_t;

   // ---------------- reference model ----------------
   function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      if (m_mis(sz, a)) return 4'd0;
      if (sz == 2'd0) return 4'(1 << (a % 4));
      if (sz == 2'd1) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
      return 4'd15;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd0) return {24'd0, d[7:0]} * 32'h01010101;
      if (sz == 2'd1) return {16'd0, d[15:0]} * 32'h00010001;
      return d;
   endfunction

   function automatic int m_req(input int w, input bit mis);
      if (mis) return 0;
      if (TO_EN && w >= TO) return TO;
      return w + 1;
   endfunction

   function automatic bit m_to(input int w, input bit mis);
      return !mis && TO_EN && (w >= TO);
   endfunction

   // ---------------- driver ----------------
   // Issues one store, acks after wait_n REQ cycles, and records what the
   // DUT showed. Cycle index c counts cycles after the start cycle.
   task automatic drive_store(input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] d, input int wait_n,
                              input bit spam, output obs_t o);
      int k;
      bit fin;
      o.req_cycles = 0;
      o.done_cyc   = -1;
      o.mis        = 1'bx;
      o.to         = 1'bx;
      o.addr       = 'x;
      o.wdata      = 'x;
      o.be         = 'x;
      o.stable     = 1'b1;
      @(posedge clk); #1;
      bus.start   = 1'b1;
      bus.size    = sz;
      bus.addr    = a;
      bus.rt_data = d;
      bus.mem_ack = 1'b0;
      k   = 0;
      fin = 1'b0;
      for (int c = 1; c <= 60 && !fin; c++) begin
         @(posedge clk); #1;
         if (spam) begin
            bus.start   = 1'b1;
            bus.size    = 2'($urandom_range(0, 3));
            bus.addr    = $urandom;
            bus.rt_data = $urandom;
         end else begin
            bus.start = 1'b0;
         end
         bus.mem_ack = 1'b0;
         if (bus.mem_req === 1'b1) begin
            if (k == 0) begin
               o.addr  = bus.mem_addr;
               o.wdata = bus.mem_wdata;
               o.be    = bus.mem_be;
            end else if (bus.mem_addr !== o.addr || bus.mem_wdata !== o.wdata ||
                         bus.mem_be !== o.be) begin
               o.stable = 1'b0;
            end
            bus.mem_ack = (k == wait_n);
            k++;
         end
         if (bus.done === 1'b1) begin
            o.done_cyc = c;
            o.mis      = bus.misalign;
            o.to       = bus.timeout;
            o.addr     = bus.mem_addr;
            o.wdata    = bus.mem_wdata;
            o.be       = bus.mem_be;
            fin        = 1'b1;
         end
      end
      o.req_cycles = k;
      // one more cycle: a start seen during RESP must not launch a store
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.mem_ack  = 1'b0;
      o.post_busy  = bus.busy;
      o.post_done  = bus.done;
      o.post_wdata = bus.mem_wdata;
      o.post_be    = bus.mem_be;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst         = 1'b1;
      bus.start   = 1'b1;
      bus.size    = 2'd2;
      bus.addr    = 32'h0000_1234;
      bus.rt_data = 32'hFFFF_FFFF;
      bus.mem_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.mem_req, bus.busy, bus.done, bus.misalign, bus.timeout} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b want=00000",
                  {bus.mem_req, bus.busy, bus.done, bus.misalign, bus.timeout});
      end
      checks++;
      if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 || bus.mem_be !== 4'd0) begin
         failures++;
         $display("FAIL reset_payload got addr=%h wdata=%h be=%b want 0", bus.mem_addr,
                  bus.mem_wdata, bus.mem_be);
      end
      checks++;
      if (bus.dbg_state !== IDLE) begin
         failures++;
         $display("FAIL reset_state got=%0d want=%0d", bus.dbg_state, IDLE);
      end
      bus.start   = 1'b0;
      bus.mem_ack = 1'b0;
      rst         = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_byte_lane();
      obs_t o;
      drive_store(2'd0, 32'h0000_1003, 32'hAABB_CCDD, 0, 1'b0, o);
      checks++;
      if (o.done_cyc != 2 || o.req_cycles != 1) begin
         failures++;
         $display("FAIL byte_timing got done=%0d req=%0d want done=2 req=1", o.done_cyc, o.req_cycles);
      end
      checks++;
      if (o.addr !== 32'h0000_1000 || o.wdata !== 32'hDDDD_DDDD || o.be !== 4'b1000) begin
         failures++;
         $display("FAIL byte_payload got %h/%h/%b want 00001000/dddddddd/1000", o.addr, o.wdata, o.be);
      end
      checks++;
      if (o.mis !== 1'b0 || o.to !== 1'b0) begin
         failures++;
         $display("FAIL byte_flags got mis=%b to=%b want 0/0", o.mis, o.to);
      end
      checks++;
      if (o.post_wdata !== 32'hDDDD_DDDD || o.post_be !== 4'b1000 || o.post_busy !== 1'b0) begin
         failures++;
         $display("FAIL byte_hold got wdata=%h be=%b busy=%b want dddddddd/1000/0",
                  o.post_wdata, o.post_be, o.post_busy);
      end
   endtask

   task automatic test_half_wait();
      obs_t o;
      drive_store(2'd1, 32'h0000_2002, 32'h1234_5678, 3, 1'b0, o);
      checks++;
      if (o.req_cycles != m_req(3, 1'b0) || o.done_cyc != m_req(3, 1'b0) + 1) begin
         failures++;
         $display("FAIL half_timing got req=%0d done=%0d want req=%0d done=%0d", o.req_cycles,
                  o.done_cyc, m_req(3, 1'b0), m_req(3, 1'b0) + 1);
      end
      checks++;
      if (o.wdata !== 32'h5678_5678 || o.be !== 4'b1100 || o.addr !== 32'h0000_2000) begin
         failures++;
         $display("FAIL half_payload got %h/%h/%b want 00002000/56785678/1100", o.addr, o.wdata, o.be);
      end
      checks++;
      if (o.stable !== 1'b1) begin
         failures++;
         $display("FAIL half_stable got=0 want=1");
      end
   endtask

   task automatic test_misalign();
      obs_t o;
      logic [1:0]  szs[2];
      logic [31:0] ads[2];
      szs[0] = 2'd2; ads[0] = 32'h0000_3001;
      szs[1] = 2'd3; ads[1] = 32'h0000_3000;
      for (int i = 0; i < 2; i++) begin
         drive_store(szs[i], ads[i], $urandom, 0, 1'b0, o);
         checks++;
         if (o.req_cycles != 0 || o.done_cyc != 1) begin
            failures++;
            $display("FAIL misalign_timing[%0d] got req=%0d done=%0d want req=0 done=1", i,
                     o.req_cycles, o.done_cyc);
         end
         checks++;
         if (o.mis !== 1'b1 || o.be !== 4'd0 || o.to !== 1'b0) begin
            failures++;
            $display("FAIL misalign_flags[%0d] got mis=%b be=%b to=%b want 1/0000/0", i, o.mis, o.be, o.to);
         end
         checks++;
         if (o.post_be !== 4'd0) begin
            failures++;
            $display("FAIL misalign_be_hold[%0d] got=%b want=0000", i, o.post_be);
         end
      end
   endtask

   task automatic test_start_spam();
      obs_t        o;
      logic [31:0] d;
      d = $urandom;
      drive_store(2'd2, 32'h0000_4000, d, 8, 1'b1, o);
      checks++;
      if (o.req_cycles != m_req(8, 1'b0) || o.done_cyc != m_req(8, 1'b0) + 1) begin
         failures++;
         $display("FAIL spam_timing got req=%0d done=%0d want req=%0d done=%0d", o.req_cycles,
                  o.done_cyc, m_req(8, 1'b0), m_req(8, 1'b0) + 1);
      end
      checks++;
      if (o.stable !== 1'b1 || o.wdata !== d || o.be !== 4'hF) begin
         failures++;
         $display("FAIL spam_payload got stable=%b wdata=%h be=%b want 1/%h/1111", o.stable,
                  o.wdata, o.be, d);
      end
      checks++;
      if (o.post_busy !== 1'b0 || o.post_done !== 1'b0) begin
         failures++;
         $display("FAIL spam_single got busy=%b done=%b want 0/0", o.post_busy, o.post_done);
      end
   endtask

   task automatic test_reset_mid_req();
      @(posedge clk); #1;
      bus.start   = 1'b1;
      bus.size    = 2'd2;
      bus.addr    = 32'h0000_5000;
      bus.rt_data = $urandom;
      bus.mem_ack = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b1) begin
         failures++;
         $display("FAIL midreq_enter got mem_req=%b want 1", bus.mem_req);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.mem_be !== 4'd0 || bus.dbg_state !== IDLE) begin
         failures++;
         $display("FAIL midreq_reset got req=%b busy=%b done=%b be=%b want 0/0/0/0000",
                  bus.mem_req, bus.busy, bus.done, bus.mem_be);
      end
      bus.mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL late_ack[%0d] got req=%b busy=%b done=%b want 0/0/0", i,
                     bus.mem_req, bus.busy, bus.done);
         end
      end
      bus.mem_ack = 1'b0;
   endtask

`ifdef SDA_TIMEOUT_EN
   task automatic test_timeout();
      obs_t o;
      drive_store(2'd2, 32'h0000_6000, $urandom, 1000, 1'b0, o);
      checks++;
      if (o.req_cycles != TO || o.done_cyc != TO + 1 || o.to !== 1'b1 || o.mis !== 1'b0) begin
         failures++;
         $display("FAIL timeout_expire got req=%0d done=%0d to=%b mis=%b want %0d/%0d/1/0",
                  o.req_cycles, o.done_cyc, o.to, o.mis, TO, TO + 1);
      end
      drive_store(2'd2, 32'h0000_6004, $urandom, TO - 1, 1'b0, o);
      checks++;
      if (o.req_cycles != TO || o.done_cyc != TO + 1 || o.to !== 1'b0) begin
         failures++;
         $display("FAIL timeout_ack_wins got req=%0d done=%0d to=%b want %0d/%0d/0",
                  o.req_cycles, o.done_cyc, o.to, TO, TO + 1);
      end
   endtask
`endif

   task automatic test_random();
      obs_t        o;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] ew;
      logic [3:0]  eb;
      int          w;
      bit          mis;
      for (int n = 0; n < 40; n++) begin
         sz  = 2'($urandom_range(0, 3));
         a   = $urandom;
         d   = $urandom;
         w   = $urandom_range(0, 6);
         mis = m_mis(sz, a);
         exp_q.push_back(m_wdata(sz, d));
         exp_be_q.push_back(m_be(sz, a));
         drive_store(sz, a, d, w, 1'b0, o);
         ew = exp_q.pop_front();
         eb = exp_be_q.pop_front();
         checks++;
         if (o.req_cycles != m_req(w, mis) || o.done_cyc != m_req(w, mis) + 1) begin
            failures++;
            $display("FAIL rand_timing[%0d] got req=%0d done=%0d want req=%0d done=%0d", n,
                     o.req_cycles, o.done_cyc, m_req(w, mis), m_req(w, mis) + 1);
         end
         checks++;
         if (o.mis !== mis || o.to !== m_to(w, mis)) begin
            failures++;
            $display("FAIL rand_flags[%0d] got mis=%b to=%b want %b/%b", n, o.mis, o.to, mis, m_to(w, mis));
         end
         checks++;
         if (o.be !== eb || o.addr !== {a[31:2], 2'b00} || (!mis && o.wdata !== ew)) begin
            failures++;
            $display("FAIL rand_payload[%0d] got %h/%h/%b want %h/%h/%b", n, o.addr, o.wdata,
                     o.be, {a[31:2], 2'b00}, ew, eb);
         end
         checks++;
         if (o.stable !== 1'b1 || o.post_busy !== 1'b0 || o.post_be !== eb) begin
            failures++;
            $display("FAIL rand_hold[%0d] got stable=%b busy=%b be=%b want 1/0/%b", n,
                     o.stable, o.post_busy, o.post_be, eb);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.size    = 2'd0;
      bus.addr    = '0;
      bus.rt_data = '0;
      bus.mem_ack = 1'b0;
      test_reset();
      test_byte_lane();
      test_half_wait();
      test_misalign();
      test_start_spam();
      test_reset_mid_req();
`ifdef SDA_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
